mode_scheduler: RTL
===================

MODE_SCHEDULER -- requirements
Module: mode_scheduler

Interface
REQ-001 Parameter ADDR_W, default 32: width of the routine start address driven to the processor fetch unit.
REQ-002 Parameter SEG_SIZE, default 256: byte spacing of per-mode routine segments in instruction memory.
REQ-003 Parameter TIMEOUT, default 1024: maximum RUN cycles allowed before fault.
REQ-004 Parameter CNT_W, default 16: cycle counter width; TIMEOUT shall be < 2**CNT_W.
REQ-005 Port list, one per line (name direction width meaning):
  clk  in  1  single clock, rising-edge.
  reset  in  1  synchronous, active-high reset.
  mode_xor  in  1  request XOR routine (mode index 0).
  mode_rshift  in  1  request right-shift routine (index 1).
  mode_lshift  in  1  request left-shift routine (index 2).
  mode_ecae  in  1  request Caesar encrypt routine (index 3).
  mode_dcae  in  1  request Caesar decrypt routine (index 4).
  mode_mul  in  1  request multiply routine (index 5).
  proc_halt  in  1  processor reached end of routine.
  fault_clr  in  1  clears FAULT state.
  proc_reset  out  1  holds processor in reset.
  pc_start  out  ADDR_W  routine base address = index * SEG_SIZE.
  start  out  1  one-cycle pulse at routine launch.
  busy  out  1  high in LOAD and RUN.
  done  out  1  one-cycle pulse on routine completion.
  active_mode  out  3  index of the current or most recent routine.
  conflict  out  1  one-cycle pulse on a rejected multi-mode request.
  overflow  out  1  sticky; a request was dropped while the pending slot was full.
  fault  out  1  high in FAULT.
  cycle_count  out  CNT_W  RUN cycles of the current or most recent routine.

Function
REQ-006 Requests shall be rising-edge detected per mode input, using a registered previous value; held levels shall not retrigger.
REQ-007 A cycle with exactly one rising edge shall form a valid request carrying that mode's index.
REQ-008 A cycle with two or more rising edges shall form no request; conflict shall pulse for one cycle.
REQ-009 States shall be IDLE, LOAD, RUN, DONE and FAULT.
REQ-010 IDLE with a valid request, or with the pending slot full: next state LOAD. A valid request is served before the pending slot.
REQ-011 On entry to LOAD, the scheduler shall set active_mode to the index, pc_start to index*SEG_SIZE and busy to 1; proc_reset stays 1 during LOAD; LOAD lasts exactly 1 cycle.
REQ-012 On LOAD->RUN, proc_reset shall go 0, start shall pulse in the first RUN cycle, and cycle_count shall clear to 0.
REQ-013 In RUN, cycle_count shall increment by 1 each cycle, with proc_halt sampled each cycle.
REQ-014 RUN with proc_halt=1: next state DONE, and cycle_count shall freeze at its value in that cycle.
REQ-015 In DONE: done=1, busy=0, proc_reset=1 for 1 cycle; next state LOAD if the pending slot is full, else IDLE.
REQ-016 RUN with proc_halt=0 and cycle_count==TIMEOUT-1: next state FAULT.
REQ-017 In FAULT: fault=1, proc_reset=1, busy=0; the pending slot is discarded; new requests are ignored.
REQ-018 FAULT with fault_clr=1: next state IDLE.
REQ-019 A valid request arriving in LOAD, RUN or DONE shall fill a one-deep pending slot if it is empty.
REQ-020 A valid request arriving while the slot is full shall be dropped, and overflow shall set.
REQ-021 Simultaneous proc_halt and a new valid request in RUN: both shall take effect (DONE, then pending served).
REQ-022 Latency from request edge to start: 2 cycles (edge seen cycle N, LOAD N+1, start N+2).

Reset
REQ-023 On reset=1 at a clock edge: state IDLE; proc_reset=1; all other outputs 0; pending slot empty; overflow cleared; edge registers cleared to 0.
REQ-024 Because edge registers clear to 0, a mode input already high when reset deasserts shall register as a rising edge.
REQ-025 Reset shall take priority over every other event, mid-RUN included.

Verification
REQ-026 Reset 1 cycle, then mode_xor=1 held -> start 2 cycles after edge, pc_start=0, active_mode=0; proc_halt after 5 RUN cycles -> done pulse, cycle_count=5; no relaunch while mode_xor is held.
REQ-027 mode_mul rises -> pc_start=1280 (5*256), active_mode=5.
REQ-028 mode_ecae and mode_dcae rise in the same cycle -> conflict pulse, no start, state stays IDLE.
REQ-029 mode_lshift runs; mode_rshift rises in RUN, then mode_xor rises -> rshift launches after DONE, xor is dropped, overflow=1.
REQ-030 mode_rshift starts with no proc_halt -> FAULT after 1024 RUN cycles, fault=1, proc_reset=1; fault_clr -> IDLE.
REQ-031 reset asserted mid-RUN -> next cycle IDLE, proc_reset=1, busy=0, cycle_count=0.

Source files
------------

// File: rtl/mode_scheduler.sv
// mode_scheduler: launches one of six processor routines on a rising-edge
// mode request and sequences the processor through LOAD/RUN/DONE. It
// queues one request that arrives while a routine is in flight, and enters
// FAULT if a routine runs past TIMEOUT cycles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mode_xor..mode_mul    mode request levels (indices 0..5)
//   proc_halt             processor reached end of routine
//   fault_clr             leave FAULT
//   proc_reset            holds processor in reset (low only in RUN)
//   pc_start              routine base address = index * SEG_SIZE
//   start / done          one-cycle pulses at launch / completion
//   busy                  high in LOAD and RUN
//   active_mode           index of current or most recent routine
//   conflict              one-cycle pulse on a rejected multi-edge request
//   overflow              sticky; request dropped with pending slot full
//   fault                 high in FAULT
//   cycle_count           RUN cycles of current or most recent routine
module mode_scheduler #(
  parameter int ADDR_W   = 32,
  parameter int SEG_SIZE = 256,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_xor,
  input  logic              mode_rshift,
  input  logic              mode_lshift,
  input  logic              mode_ecae,
  input  logic              mode_dcae,
  input  logic              mode_mul,
  input  logic              proc_halt,
  input  logic              fault_clr,
  output logic              proc_reset,
  output logic [ADDR_W-1:0] pc_start,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        active_mode,
  output logic              conflict,
  output logic              overflow,
  output logic              fault,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, FAULT} state_t;

  state_t     state, state_n;
  logic [5:0] mode_in, mode_prev, rise;
  logic       req_valid, multi;
  logic [2:0] req_idx;
  logic       pend_v;
  logic [2:0] pend_idx;
  logic       launch, pop;
  logic [2:0] launch_idx;

  assign mode_in = {mode_mul, mode_dcae, mode_ecae, mode_lshift, mode_rshift, mode_xor};
  assign rise    = mode_in & ~mode_prev;

  // Exactly one edge forms a request; two or more are rejected outright.
  assign req_valid = $onehot(rise);
  assign multi     = (|rise) && !req_valid;

  always_comb begin
    req_idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (rise[i]) req_idx = 3'(i);
  end

  // Next state. A fresh request in IDLE wins over the pending slot, which
  // stays occupied and is served after that routine's DONE.
  always_comb begin
    state_n    = state;
    launch     = 1'b0;
    pop        = 1'b0;
    launch_idx = req_idx;
    case (state)
      IDLE: begin
        if (req_valid) begin
          launch = 1'b1;
        end else if (pend_v) begin
          launch     = 1'b1;
          pop        = 1'b1;
          launch_idx = pend_idx;
        end
        if (launch) state_n = LOAD;
      end
      LOAD: state_n = RUN;
      RUN: begin
        if (proc_halt)                             state_n = DONE;
        else if (cycle_count == CNT_W'(TIMEOUT-1)) state_n = FAULT;
      end
      DONE: begin
        if (pend_v) begin
          launch     = 1'b1;
          pop        = 1'b1;
          launch_idx = pend_idx;
          state_n    = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      FAULT: if (fault_clr) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Edge registers, pending slot and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_prev <= '0;
      pend_v    <= 1'b0;
      pend_idx  <= 3'd0;
      overflow  <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      mode_prev <= mode_in;
      conflict  <= multi;
      if (state == FAULT) begin
        pend_v <= 1'b0;
      end else begin
        if (pop) pend_v <= 1'b0;
        // A request in DONE while the slot is being consumed still sees it
        // full and is dropped.
        if (req_valid && (state == LOAD || state == RUN || state == DONE)) begin
          if (!pend_v) begin
            pend_v   <= 1'b1;
            pend_idx <= req_idx;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  // Launch registers and the RUN cycle counter. The counter holds on halt
  // so it reports the length of the last routine.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode <= 3'd0;
      pc_start    <= '0;
      start       <= 1'b0;
      cycle_count <= '0;
    end else begin
      start <= (state == LOAD);
      if (launch) begin
        active_mode <= launch_idx;
        pc_start    <= ADDR_W'(launch_idx) * ADDR_W'(SEG_SIZE);
      end
      if (state == LOAD)                 cycle_count <= '0;
      else if (state == RUN && !proc_halt) cycle_count <= cycle_count + 1'b1;
    end
  end

  assign proc_reset = (state != RUN);
  assign busy       = (state == LOAD) || (state == RUN);
  assign done       = (state == DONE);
  assign fault      = (state == FAULT);

endmodule
